// File: rtl/rf_pkg.sv
// Shared register-file definitions: widths, register count and arbiter priority encoding.
package rf_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  // Which requester wins when both ask in the same cycle
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: req[0] is requester A, req[1] is requester B.
module rr_arb2
  import rf_pkg::prio_t;
  import rf_pkg::PRIO_A;
(
  input  logic [1:0] req,
  input  prio_t      prio,
  output logic [1:0] gnt
);

  // Lone requester always wins; on contention the priority holder wins
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (prio == PRIO_A) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two register-file write requesters onto one write port with a
// one-cycle registered output, alternating priority and a contention counter.
module rf_write_arbiter
  import rf_pkg::prio_t;
  import rf_pkg::PRIO_A;
  import rf_pkg::PRIO_B;
#(
  parameter int unsigned DATA_W = rf_pkg::DATA_W,
  parameter int unsigned ADDR_W = rf_pkg::ADDR_W,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [DATA_W-1:0] Rdst,
  output logic [ADDR_W-1:0] Rdst_addr,
  output logic              Rwrite,
  output logic [CNT_W-1:0]  conflict_cnt
);

  prio_t      prio_q;
  prio_t      prio_d;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       xfer;

  // Requests are masked during reset so nothing is accepted then
  assign req = {b_valid & ~rst, a_valid & ~rst};

  rr_arb2 u_arb (
    .req  (req),
    .prio (prio_q),
    .gnt  (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign xfer    = |gnt;

  // Priority register
  always_ff @(posedge clk) begin
    if (rst) prio_q <= PRIO_A;
    else     prio_q <= prio_d;
  end

  // After a grant, priority passes to the requester that was not granted
  always_comb begin
    prio_d = prio_q;
    if (gnt[0])      prio_d = PRIO_B;
    else if (gnt[1]) prio_d = PRIO_A;
  end

  // Registered write port; payload holds its last value when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      Rwrite    <= 1'b0;
      Rdst      <= '0;
      Rdst_addr <= '0;
    end else begin
      Rwrite <= xfer;
      if (gnt[0]) begin
        Rdst      <= a_data;
        Rdst_addr <= a_addr;
      end else if (gnt[1]) begin
        Rdst      <= b_data;
        Rdst_addr <= b_addr;
      end
    end
  end

  // Saturating count of cycles with both requesters valid
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (a_valid && b_valid && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a short constrained-random tail.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic [15:0] Rdst;
  logic [4:0]  Rdst_addr;
  logic        Rwrite;
  logic [7:0]  conflict_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [15:0] rf_model [32];

  rf_write_arbiter #(.DATA_W(16), .ADDR_W(5), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .Rdst         (Rdst),
    .Rdst_addr    (Rdst_addr),
    .Rwrite       (Rwrite),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Register-file model fed by the write port
  always @(posedge clk) begin
    if (Rwrite) rf_model[Rdst_addr] <= Rdst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic w, input logic [4:0] ad,
                         input logic [15:0] d);
    chk({tag, ".Rwrite"}, {31'b0, Rwrite}, {31'b0, w});
    chk({tag, ".Rdst_addr"}, {27'b0, Rdst_addr}, {27'b0, ad});
    chk({tag, ".Rdst"}, {16'b0, Rdst}, {16'b0, d});
  endtask

  task automatic chk_rdy(input string tag, input logic ra, input logic rb);
    chk({tag, ".a_ready"}, {31'b0, a_ready}, {31'b0, ra});
    chk({tag, ".b_ready"}, {31'b0, b_ready}, {31'b0, rb});
  endtask

  initial begin
    logic        m_prio;
    logic        ga, gb;
    logic        e_w;
    logic [4:0]  e_addr;
    logic [15:0] e_data;
    logic [7:0]  e_cnt;
    int unsigned a_wait, b_wait;

    for (int i = 0; i < 32; i++) rf_model[i] = 16'h0;

    // Reset with both requesters valid: nothing may be accepted
    rst = 1'b1;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 16'hDEAD;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 16'hBEEF;
    #1;
    chk_rdy("rst_rdy", 1'b0, 1'b0);
    tick();
    tick();
    chk_rdy("rst_rdy2", 1'b0, 1'b0);
    chk_out("rst_out", 1'b0, 5'd0, 16'h0);
    chk("rst_cnt", {24'b0, conflict_cnt}, 32'd0);

    // A alone: accepted, written one cycle later, then idle
    rst = 1'b0;
    b_valid = 1'b0;
    a_addr = 5'd3; a_data = 16'h1234;
    #1;
    chk_rdy("a_only_rdy", 1'b1, 1'b0);
    tick();
    chk_out("a_only_wr", 1'b1, 5'd3, 16'h1234);
    a_valid = 1'b0;
    #1;
    chk_rdy("idle_rdy", 1'b0, 1'b0);
    tick();
    chk_out("a_only_idle", 1'b0, 5'd3, 16'h1234);

    // B alone to address 0, which is an ordinary register; priority returns to A
    b_valid = 1'b1; b_addr = 5'd0; b_data = 16'h5A5A;
    #1;
    chk_rdy("b_only_rdy", 1'b0, 1'b1);
    tick();
    b_valid = 1'b0;
    chk_out("b_only_wr", 1'b1, 5'd0, 16'h5A5A);
    tick();
    chk("r0_written", {16'b0, rf_model[0]}, 32'h5A5A);
    chk("cnt_no_contention", {24'b0, conflict_cnt}, 32'd0);

    // Contention for 4 cycles: A,B,A,B back to back
    a_valid = 1'b1; a_addr = 5'd1; a_data = 16'h1111;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 16'h2222;
    #1; chk_rdy("cont0_rdy", 1'b1, 1'b0);
    tick(); chk_out("cont0_wr", 1'b1, 5'd1, 16'h1111);
    chk_rdy("cont1_rdy", 1'b0, 1'b1);
    tick(); chk_out("cont1_wr", 1'b1, 5'd2, 16'h2222);
    chk_rdy("cont2_rdy", 1'b1, 1'b0);
    tick(); chk_out("cont2_wr", 1'b1, 5'd1, 16'h1111);
    chk_rdy("cont3_rdy", 1'b0, 1'b1);
    tick(); chk_out("cont3_wr", 1'b1, 5'd2, 16'h2222);
    chk("cont_cnt", {24'b0, conflict_cnt}, 32'd4);

    // Same address from both ports: A lands first, B last
    a_addr = 5'd7; a_data = 16'hAAAA;
    b_addr = 5'd7; b_data = 16'hBBBB;
    #1; chk_rdy("same0_rdy", 1'b1, 1'b0);
    tick();
    a_valid = 1'b0;
    chk_out("same0_wr", 1'b1, 5'd7, 16'hAAAA);
    #1; chk_rdy("same1_rdy", 1'b0, 1'b1);
    tick();
    b_valid = 1'b0;
    chk_out("same1_wr", 1'b1, 5'd7, 16'hBBBB);
    tick();
    chk("r7_final", {16'b0, rf_model[7]}, 32'hBBBB);
    chk("same_cnt", {24'b0, conflict_cnt}, 32'd5);
    chk_out("same_idle", 1'b0, 5'd7, 16'hBBBB);

    // Reset right after an accepted write discards the pending output
    a_valid = 1'b1; a_addr = 5'd12; a_data = 16'hC0DE;
    #1; chk_rdy("rstx_rdy", 1'b1, 1'b0);
    tick();
    a_valid = 1'b0;
    rst = 1'b1;
    chk_out("rstx_pre", 1'b1, 5'd12, 16'hC0DE);
    tick();
    chk_out("rstx_post", 1'b0, 5'd0, 16'h0);
    chk("rstx_cnt", {24'b0, conflict_cnt}, 32'd0);
    rst = 1'b0;
    a_valid = 1'b1; a_addr = 5'd4; a_data = 16'h4444;
    b_valid = 1'b1; b_addr = 5'd5; b_data = 16'h5555;
    #1; chk_rdy("rstx_prio_a", 1'b1, 1'b0);
    chk_out("rstx_idle", 1'b0, 5'd0, 16'h0);

    // Sustained contention saturates the counter at 255
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254 || i == 255 || i == 256 || i == 300)
        chk($sformatf("sat_cnt_%0d", i), {24'b0, conflict_cnt}, (i > 255) ? 32'd255 : i);
    end
    chk("sat_rwrite", {31'b0, Rwrite}, 32'd1);

    // Random valids, stable payload until granted; small reference model
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    tick();
    rst = 1'b0;
    m_prio = 1'b0; e_w = 1'b0; e_addr = 5'd0; e_data = 16'h0; e_cnt = 8'd0;
    a_wait = 0; b_wait = 0;
    for (int i = 0; i < 2000; i++) begin
      #1;
      ga = a_valid && (!b_valid || !m_prio);
      gb = b_valid && (!a_valid || m_prio);
      if (a_ready !== ga || b_ready !== gb)
        chk_rdy($sformatf("rnd_rdy_%0d", i), ga, gb);
      a_wait = (a_valid && !a_ready) ? a_wait + 1 : 0;
      b_wait = (b_valid && !b_ready) ? b_wait + 1 : 0;
      if (a_wait > 1 || b_wait > 1)
        chk($sformatf("rnd_starve_%0d", i), a_wait > b_wait ? a_wait : b_wait, 32'd1);
      e_w = ga || gb;
      if (ga) begin e_addr = a_addr; e_data = a_data; m_prio = 1'b1; end
      else if (gb) begin e_addr = b_addr; e_data = b_data; m_prio = 1'b0; end
      if (a_valid && b_valid && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
      tick();
      if (Rwrite !== e_w || Rdst_addr !== e_addr || Rdst !== e_data)
        chk_out($sformatf("rnd_out_%0d", i), e_w, e_addr, e_data);
      else
        checks++;
      chk("rnd_cnt", {24'b0, conflict_cnt}, {24'b0, e_cnt});
      if (!a_valid || ga) begin
        a_valid = 1'($urandom_range(0, 1));
        a_addr = 5'($urandom); a_data = 16'($urandom);
      end
      if (!b_valid || gb) begin
        b_valid = 1'($urandom_range(0, 1));
        b_addr = 5'($urandom); b_data = 16'($urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
